// File: rtl/norm_pkg.sv
// Shared types and helpers for the shared normalize scheduler.
package norm_pkg;

    localparam int MANT_W    = 8;
    localparam int MAX_IDW   = 3;
    localparam int MAX_EXP_W = 16;

    typedef struct packed {
        logic [MAX_IDW-1:0]   id;
        logic [MANT_W-1:0]    mant;
        logic [MAX_EXP_W-1:0] exp;
        logic                 zero;
        logic                 uflow;
    } norm_result_t;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            r = ((1 << i) < value) ? (i + 1) : r;
        end
        return r;
    endfunction

endpackage

// File: rtl/lzd8.sv
// 8-bit leading-zero detector: valid=0 for an all-zero input.
module lzd8 (
    input  logic [7:0] d,
    output logic       valid,
    output logic [2:0] pos
);

    // Priority encode from the MSB down.
    always_comb begin
        valid = |d;
        casez (d)
            8'b1???????: pos = 3'd0;
            8'b01??????: pos = 3'd1;
            8'b001?????: pos = 3'd2;
            8'b0001????: pos = 3'd3;
            8'b00001???: pos = 3'd4;
            8'b000001??: pos = 3'd5;
            8'b0000001?: pos = 3'd6;
            8'b00000001: pos = 3'd7;
            default:     pos = 3'd0;
        endcase
    end

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot combinational grant, pointer moves past the winner.
module rr_arbiter
    import norm_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDW  = clog2(NREQ)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            en,
    input  logic [NREQ-1:0] req,
    output logic [NREQ-1:0] gnt,
    output logic [IDW-1:0]  gnt_id,
    output logic            gnt_any
);

    logic [IDW-1:0] ptr_q;
    logic [IDW-1:0] ptr_d;
    logic [IDW-1:0] idx_s;
    logic           hit_s;
    int             sum_s;

    // Search from ptr_q upward with wrap; first requesting row wins.
    always_comb begin
        gnt     = '0;
        gnt_id  = '0;
        gnt_any = 1'b0;
        idx_s   = '0;
        hit_s   = 1'b0;
        sum_s   = 0;
        for (int i = 0; i < NREQ; i++) begin
            sum_s   = int'(ptr_q) + i;
            sum_s   = (sum_s >= NREQ) ? (sum_s - NREQ) : sum_s;
            idx_s   = IDW'(sum_s);
            hit_s   = en & ~gnt_any & req[idx_s];
            gnt[idx_s] = hit_s;
            gnt_id  = hit_s ? idx_s : gnt_id;
            gnt_any = gnt_any | hit_s;
        end
    end

    // Next pointer: one past the granted row, held when idle.
    always_comb begin
        if (gnt_any) begin
            ptr_d = (gnt_id == IDW'(NREQ - 1)) ? '0 : (gnt_id + 1'b1);
        end else begin
            ptr_d = ptr_q;
        end
    end

    // Pointer register.
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/norm_rr_scheduler.sv
// Shares one LZC/normalize datapath between NREQ PE rows via round-robin
// arbitration; two-stage pipeline (capture, normalize) with backpressure.
module norm_rr_scheduler
    import norm_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int EXP_W = 8,
    parameter int IDW   = clog2(NREQ)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NREQ-1:0]       req,
    input  logic [8*NREQ-1:0]     req_mant,
    input  logic [EXP_W*NREQ-1:0] req_exp,
    output logic [NREQ-1:0]       gnt,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [IDW-1:0]        out_id,
    output logic [7:0]            out_mant,
    output logic [EXP_W-1:0]      out_exp,
    output logic                  out_zero,
    output logic                  out_uflow
);

    logic               a_valid_q;
    logic [MANT_W-1:0]  a_mant_q;
    logic [EXP_W-1:0]   a_exp_q;
    logic [IDW-1:0]     a_id_q;
    logic               b_valid_q;
    norm_result_t       b_q;
    norm_result_t       b_d;

    logic               a_adv_s;
    logic               a_accept_s;
    logic               arb_en_s;
    logic [IDW-1:0]     gnt_id_s;
    logic               gnt_any_s;
    logic [MANT_W-1:0]  sel_mant_s;
    logic [EXP_W-1:0]   sel_exp_s;
    logic               lzc_valid_s;
    logic [2:0]         lzc_s;
    logic [EXP_W-1:0]   lzc_ext_s;
    logic               unused_b_bits_s;

    // Stall only when both stages hold data and downstream refuses it.
    assign a_adv_s    = a_valid_q & (~b_valid_q | out_ready);
    assign a_accept_s = ~a_valid_q | a_adv_s;
    assign arb_en_s   = a_accept_s & ~reset;

    rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_arb (
        .clk     (clk),
        .reset   (reset),
        .en      (arb_en_s),
        .req     (req),
        .gnt     (gnt),
        .gnt_id  (gnt_id_s),
        .gnt_any (gnt_any_s)
    );

    // One-hot AND-OR select of the granted row's operands.
    always_comb begin
        sel_mant_s = '0;
        sel_exp_s  = '0;
        for (int k = 0; k < NREQ; k++) begin
            sel_mant_s = sel_mant_s | (req_mant[8*k +: 8] & {MANT_W{gnt[k]}});
            sel_exp_s  = sel_exp_s | (req_exp[EXP_W*k +: EXP_W] & {EXP_W{gnt[k]}});
        end
    end

    lzd8 u_lzd (
        .d     (a_mant_q),
        .valid (lzc_valid_s),
        .pos   (lzc_s)
    );

    assign lzc_ext_s = EXP_W'(lzc_s);

    // Normalize stage A contents; zero and underflow flush to 0/0.
    always_comb begin
        b_d    = '0;
        b_d.id = MAX_IDW'(a_id_q);
        if (!lzc_valid_s) begin
            b_d.zero = 1'b1;
        end else if (lzc_ext_s > a_exp_q) begin
            b_d.uflow = 1'b1;
        end else begin
            b_d.mant = a_mant_q << lzc_s;
            b_d.exp  = MAX_EXP_W'(a_exp_q - lzc_ext_s);
        end
    end

    // Pipeline registers for capture (A) and output (B) stages.
    always_ff @(posedge clk) begin
        if (reset) begin
            a_valid_q <= 1'b0;
            a_mant_q  <= '0;
            a_exp_q   <= '0;
            a_id_q    <= '0;
            b_valid_q <= 1'b0;
            b_q       <= '0;
        end else begin
            if (gnt_any_s) begin
                a_valid_q <= 1'b1;
                a_mant_q  <= sel_mant_s;
                a_exp_q   <= sel_exp_s;
                a_id_q    <= gnt_id_s;
            end else if (a_adv_s) begin
                a_valid_q <= 1'b0;
            end else begin
                a_valid_q <= a_valid_q;
            end
            if (a_adv_s) begin
                b_valid_q <= 1'b1;
                b_q       <= b_d;
            end else if (out_ready) begin
                b_valid_q <= 1'b0;
            end else begin
                b_valid_q <= b_valid_q;
            end
        end
    end

    assign out_valid       = b_valid_q;
    assign out_id          = IDW'(b_q.id);
    assign out_mant        = b_q.mant;
    assign out_exp         = EXP_W'(b_q.exp);
    assign out_zero        = b_q.zero;
    assign out_uflow       = b_q.uflow;
    assign unused_b_bits_s = ^b_q;

endmodule

// File: doc/norm_rr_scheduler.md
Name: norm_rr_scheduler

Overview:
- Shares one 8-bit leading-zero-count/normalize datapath between NREQ systolic-array PE rows.
- Each row posts an unnormalized mantissa/exponent result; a round-robin arbiter grants one row per cycle.
- A 2-stage pipeline (capture, LZC+shift) returns the normalized result with the row index.
- Sits between the PE-row accumulators and the output writeback.

Parameters:
- NREQ, 4, number of requesting PE rows (2..8)
- EXP_W, 8, exponent width
- IDW, 2, requester-index width, equal to clog2(NREQ)

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  synchronous, active-high reset
- req  in  NREQ  per-row request; must hold with data until granted
- req_mant  in  8*NREQ  row k mantissa at [8k+7:8k]
- req_exp  in  EXP_W*NREQ  row k exponent at [EXP_W*k+EXP_W-1:EXP_W*k]
- gnt  out  NREQ  one-hot; the request and data are accepted on this clock edge
- out_valid  out  1  normalized result valid
- out_ready  in  1  downstream accepts when out_valid&&out_ready
- out_id  out  IDW  originating row index
- out_mant  out  8  normalized mantissa; bit7=1 unless zero or underflow
- out_exp  out  EXP_W  adjusted exponent
- out_zero  out  1  input mantissa was 0
- out_uflow  out  1  underflow flushed to zero

Behaviour:
- Reset values: gnt=0, out_valid=0, out_id=0, out_mant=0, out_exp=0, out_zero=0, out_uflow=0. Both stage valids are 0. The RR pointer gives row 0 highest priority.
- Reset mid-operation: in-flight results are dropped without being delivered; gnt=0 during any cycle with reset=1.
- Arbiter: combinational gnt.
  - Search order starts at ptr and wraps modulo NREQ.
  - At most one grant per cycle, and only when stage A can accept.
  - On a grant to row k, ptr <= (k+1) mod NREQ. ptr is unchanged with no grant.
- Stage A (capture): on a grant edge, capture mant, exp and id, and set a_valid.
- Stage B (output register) computes from stage A:
  - lzc = leading-zero count of the mantissa, 0..7. The detector returns valid=0 for mant==0.
  - mant==0 -> out_mant=0, out_exp=0, out_zero=1, out_uflow=0.
  - lzc > exp -> out_mant=0, out_exp=0, out_uflow=1.
  - otherwise out_mant = mant << lzc and out_exp = exp - lzc (lzc zero-extended to EXP_W). lzc==exp is legal and gives exp 0.
- Latency: grant edge to out_valid = 2 cycles. Sustained throughput is 1 result/cycle with out_ready=1.
- Backpressure:
  - B holds all outputs stable while out_valid && !out_ready.
  - A advances into B when !b_valid or out_ready.
  - A accepts a grant when !a_valid or A advances this cycle.
  - Full stall: both stages valid and out_ready=0 -> gnt=0. No data is lost or duplicated.
- Simultaneous events: an out_ready handshake, an A->B move and a new grant can all occur in one cycle.
- Requests not granted keep waiting. Starvation bound: NREQ-1 grants to other rows.
- No combinational path from req to out_*. The only path from out_ready to gnt is through the stall logic.

Decomposition:
- Shared package norm_pkg holds:
  - MANT_W=8
  - a norm_result struct {id, mant, exp, zero, uflow}
  - the function clog2
- Sub-modules:
  - rr_arbiter (NREQ, one-hot grant, pointer update on an enable input).
  - The team's existing 8-bit leading-zero detector (valid + 3-bit position), instantiated in stage B.
  - Shift/subtract stays inline.

Test Plan:
- Single request: row 2 with mant=0x13, exp=10 -> gnt=0100 at cycle 0; at cycle 2 out_id=2, out_mant=0x98, out_exp=7, zero=0, uflow=0.
- All four rows requesting continuously, out_ready=1 -> grants in order 0,1,2,3,0,... One result per cycle from cycle 2; ids match the grant order.
- Boundary values:
  - mant=0x00, exp=5 -> out_zero=1, mant=0, exp=0.
  - mant=0x01, exp=3 -> uflow=1, mant=0, exp=0.
  - mant=0x01, exp=7 -> mant=0x80, exp=0.
  - mant=0x80, exp=0 -> unchanged.
- Backpressure: out_ready=0 for 5 cycles with 4 rows requesting -> exactly 2 grants, then gnt=0 and outputs stable. On release, in-order delivery with no loss or duplicates.
- Reset asserted while both stages are valid -> next cycle out_valid=0 and gnt=0. After release with rows 1 and 3 requesting, row 1 is granted first (ptr=0).
